// File: rtl/ctrl_decode.sv
// Instruction decode and control for the single-cycle core: EX controls, RF/DM/PC
// controls, architectural {Z,V,N} flag register and the BOOT/RUN/HALT sequencer.
module ctrl_decode #(
  parameter int OPW = 4,
  parameter int RAW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    instr,
  input  logic           stall,
  input  logic           zr,
  input  logic           ov,
  input  logic           neg,
  output logic [2:0]     func,
  output logic [3:0]     shamt,
  output logic           src1sel,
  output logic [7:0]     imm8,
  output logic [RAW-1:0] p0_addr,
  output logic [RAW-1:0] p1_addr,
  output logic           re0,
  output logic           re1,
  output logic [RAW-1:0] dst_addr,
  output logic           we_rf,
  output logic           we_dm,
  output logic           re_dm,
  output logic [1:0]     wb_sel,
  output logic           br_taken,
  output logic           jal,
  output logic           jr,
  output logic [2:0]     flags,
  output logic           hlt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'h0, OP_RSV = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_NOR = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
    OP_B   = 4'hC, OP_JAL = 4'hD, OP_JR  = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  state_t   state_q, state_d;
  logic [2:0] flags_q, flags_d;
  opcode_t  opcode;
  logic [RAW-1:0] rd, rs, rt;
  logic     z_f, v_f, n_f;
  logic     cond;
  logic     dec_we_rf, dec_we_dm, dec_re_dm, dec_br, dec_jal, dec_jr;
  logic     side_ok;

  assign opcode = opcode_t'(instr[15 -: OPW]);
  assign rd     = instr[11:8];
  assign rs     = instr[7:4];
  assign rt     = instr[3:0];
  assign z_f    = flags_q[2];
  assign v_f    = flags_q[1];
  assign n_f    = flags_q[0];
  assign shamt  = instr[3:0];
  assign flags  = flags_q;
  assign hlt    = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    cond = 1'b0;
    unique case (instr[11:9])
      3'b000: cond = !z_f;
      3'b001: cond = z_f;
      3'b010: cond = !z_f && !n_f;
      3'b011: cond = n_f;
      3'b100: cond = z_f || !n_f;
      3'b101: cond = n_f || z_f;
      3'b110: cond = v_f;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          case (opcode)
            OP_ADD, OP_SUB: flags_d = {zr, ov, neg};
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: flags_d = {zr, flags_q[1:0]};
            OP_HLT: state_d = HALT;
            default: ;
          endcase
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Decode only acts in RUN; BOOT and HALT leave every control at its idle value.
  always_comb begin
    func      = '0;
    src1sel   = 1'b0;
    imm8      = '0;
    p0_addr   = '0;
    p1_addr   = '0;
    re0       = 1'b0;
    re1       = 1'b0;
    dst_addr  = '0;
    wb_sel    = 2'b00;
    dec_we_rf = 1'b0;
    dec_we_dm = 1'b0;
    dec_re_dm = 1'b0;
    dec_br    = 1'b0;
    dec_jal   = 1'b0;
    dec_jr    = 1'b0;
    if (state_q == RUN) begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_NOR: begin
          func      = instr[14:12];
          p0_addr   = rs;
          p1_addr   = rt;
          re0       = 1'b1;
          re1       = 1'b1;
          dst_addr  = rd;
          dec_we_rf = 1'b1;
        end
        OP_SLL, OP_SRL, OP_SRA: begin
          func      = instr[14:12];
          p0_addr   = rs;
          re0       = 1'b1;
          src1sel   = 1'b1;
          dst_addr  = rd;
          dec_we_rf = 1'b1;
        end
        OP_LW, OP_SW: begin
          p0_addr = rs;
          re0     = 1'b1;
          src1sel = 1'b1;
          imm8    = {{4{instr[3]}}, instr[3:0]};
          if (opcode == OP_LW) begin
            dec_re_dm = 1'b1;
            dec_we_rf = 1'b1;
            dst_addr  = rd;
            wb_sel    = 2'b01;
          end else begin
            p1_addr   = rd;
            re1       = 1'b1;
            dec_we_dm = 1'b1;
          end
        end
        OP_LHB: begin
          func      = 3'b001;
          p0_addr   = rd;
          re0       = 1'b1;
          imm8      = instr[7:0];
          src1sel   = 1'b1;
          dst_addr  = rd;
          dec_we_rf = 1'b1;
        end
        OP_LLB: begin
          re0       = 1'b1;
          imm8      = instr[7:0];
          src1sel   = 1'b1;
          dst_addr  = rd;
          dec_we_rf = 1'b1;
        end
        OP_B:   dec_br = cond;
        OP_JAL: begin
          dec_jal   = 1'b1;
          dec_we_rf = 1'b1;
          dst_addr  = '1;
          wb_sel    = 2'b10;
        end
        OP_JR: begin
          dec_jr  = 1'b1;
          p0_addr = rs;
          re0     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign side_ok  = !stall;
  assign we_rf    = dec_we_rf && side_ok && (dst_addr != '0);
  assign we_dm    = dec_we_dm && side_ok;
  assign re_dm    = dec_re_dm && side_ok;
  assign br_taken = dec_br && side_ok;
  assign jal      = dec_jal && side_ok;
  assign jr       = dec_jr && side_ok;

endmodule

// File: tb/tb_ctrl_decode.sv
// Scoreboard bench for ctrl_decode: a reference model pushes expected controls per
// cycle, popped and compared on the falling edge.
module tb_ctrl_decode;

  logic        clk = 1'b0;
  logic        rst_n, stall, zr, ov, neg;
  logic [15:0] instr;
  logic [2:0]  func;
  logic [3:0]  shamt, p0_addr, p1_addr, dst_addr;
  logic        src1sel, re0, re1, we_rf, we_dm, re_dm, br_taken, jal, jr, hlt;
  logic [7:0]  imm8;
  logic [1:0]  wb_sel;
  logic [2:0]  flags;

  typedef struct packed {
    logic [2:0] func;   logic [3:0] shamt; logic src1sel; logic [7:0] imm8;
    logic [3:0] p0;     logic [3:0] p1;    logic re0;     logic re1;
    logic [3:0] dst;    logic we_rf;       logic we_dm;   logic re_dm;
    logic [1:0] wb_sel; logic br;          logic jal;     logic jr;
    logic [2:0] flags;  logic hlt;
  } out_t;

  out_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_state;
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  ctrl_decode #(.OPW(4), .RAW(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .stall(stall), .zr(zr), .ov(ov), .neg(neg),
    .func(func), .shamt(shamt), .src1sel(src1sel), .imm8(imm8),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .dst_addr(dst_addr), .we_rf(we_rf), .we_dm(we_dm), .re_dm(re_dm),
    .wb_sel(wb_sel), .br_taken(br_taken), .jal(jal), .jr(jr),
    .flags(flags), .hlt(hlt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // States: 0 BOOT, 1 RUN, 2 HALT
  function automatic out_t model_out(input int st, input logic [2:0] fl,
                                     input logic [15:0] ins, input logic stl);
    out_t o;
    logic [3:0] op, rd, rs, rt;
    logic z, v, n, c;
    o = '0;
    o.shamt = ins[3:0];
    o.flags = fl;
    o.hlt   = (st == 2);
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    {z, v, n} = fl;
    if (st == 1) begin
      if (op == 4'h0 || op == 4'h2 || op == 4'h3 || op == 4'h4) begin
        o.func = op[2:0]; o.p0 = rs; o.p1 = rt; o.re0 = 1; o.re1 = 1;
        o.dst = rd; o.we_rf = (rd != 0);
      end else if (op >= 4'h5 && op <= 4'h7) begin
        o.func = op[2:0]; o.p0 = rs; o.re0 = 1; o.src1sel = 1;
        o.dst = rd; o.we_rf = (rd != 0);
      end else if (op == 4'h8) begin
        o.p0 = rs; o.re0 = 1; o.src1sel = 1; o.imm8 = {{4{rt[3]}}, rt};
        o.re_dm = 1; o.we_rf = (rd != 0); o.dst = rd; o.wb_sel = 2'b01;
      end else if (op == 4'h9) begin
        o.p0 = rs; o.re0 = 1; o.src1sel = 1; o.imm8 = {{4{rt[3]}}, rt};
        o.p1 = rd; o.re1 = 1; o.we_dm = 1;
      end else if (op == 4'hA) begin
        o.func = 3'b001; o.p0 = rd; o.re0 = 1; o.imm8 = ins[7:0];
        o.src1sel = 1; o.dst = rd; o.we_rf = (rd != 0);
      end else if (op == 4'hB) begin
        o.re0 = 1; o.imm8 = ins[7:0]; o.src1sel = 1; o.dst = rd; o.we_rf = (rd != 0);
      end else if (op == 4'hC) begin
        case (ins[11:9])
          3'd0: c = !z;        3'd1: c = z;
          3'd2: c = !z && !n;  3'd3: c = n;
          3'd4: c = z || !n;   3'd5: c = n || z;
          3'd6: c = v;         default: c = 1'b1;
        endcase
        o.br = c;
      end else if (op == 4'hD) begin
        o.jal = 1; o.we_rf = 1; o.dst = 4'd15; o.wb_sel = 2'b10;
      end else if (op == 4'hE) begin
        o.jr = 1; o.p0 = rs; o.re0 = 1;
      end
      if (stl) begin
        o.we_rf = 0; o.we_dm = 0; o.re_dm = 0; o.br = 0; o.jal = 0; o.jr = 0;
      end
    end
    return o;
  endfunction

  task automatic model_tick(input logic [15:0] ins, input logic stl,
                            input logic z, input logic v, input logic n, input logic r);
    logic [3:0] op;
    op = ins[15:12];
    if (!r) begin
      m_state = 0; m_flags = 3'b000;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 && !stl) begin
      if (op == 4'h0 || op == 4'h2) m_flags = {z, v, n};
      else if (op == 4'h3 || (op >= 4'h4 && op <= 4'h7)) m_flags[2] = z;
      if (op == 4'hF) m_state = 2;
    end
  endtask

  task automatic compare(input out_t e);
    check("func", 16'(func), 16'(e.func));
    check("shamt", 16'(shamt), 16'(e.shamt));
    check("src1sel", 16'(src1sel), 16'(e.src1sel));
    check("imm8", 16'(imm8), 16'(e.imm8));
    check("p0_addr", 16'(p0_addr), 16'(e.p0));
    check("p1_addr", 16'(p1_addr), 16'(e.p1));
    check("re0", 16'(re0), 16'(e.re0));
    check("re1", 16'(re1), 16'(e.re1));
    check("dst_addr", 16'(dst_addr), 16'(e.dst));
    check("we_rf", 16'(we_rf), 16'(e.we_rf));
    check("we_dm", 16'(we_dm), 16'(e.we_dm));
    check("re_dm", 16'(re_dm), 16'(e.re_dm));
    check("wb_sel", 16'(wb_sel), 16'(e.wb_sel));
    check("br_taken", 16'(br_taken), 16'(e.br));
    check("jal", 16'(jal), 16'(e.jal));
    check("jr", 16'(jr), 16'(e.jr));
    check("flags", 16'(flags), 16'(e.flags));
    check("hlt", 16'(hlt), 16'(e.hlt));
  endtask

  task automatic step(input logic [15:0] i, input logic s, input logic z,
                      input logic v, input logic n, input logic r = 1'b1);
    instr = i; stall = s; zr = z; ov = v; neg = n; rst_n = r;
    sb_q.push_back(model_out(m_state, m_flags, i, s));
    @(negedge clk);
    if (sb_q.size() == 0) check("sb_empty", 16'd1, 16'd0);
    else compare(sb_q.pop_front());
    @(posedge clk);
    model_tick(i, s, z, v, n, r);
    #1;
  endtask

  initial begin
    logic [15:0] ri;
    rst_n = 1'b0; instr = '0; stall = 1'b0; zr = 1'b0; ov = 1'b0; neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_state = 0; m_flags = 3'b000;

    // BOOT cycle then ADD R1,R2,R3 with zr=1
    step(16'h0123, 0, 1, 0, 0);
    step(16'h0123, 0, 1, 0, 0);
    // SUB sets V,N; B V taken
    step(16'h2123, 0, 0, 1, 1);
    step(16'hCC00, 0, 0, 0, 0);
    step(16'h2123, 0, 0, 1, 1);
    step(16'hC200, 0, 0, 0, 0);
    // AND with zr=1 keeps V,N
    step(16'h3123, 0, 1, 0, 0);
    step(16'hCA00, 0, 0, 0, 0);
    // LW / SW, shifts, LHB, LLB, JR, write to R0
    step(16'h845F, 0, 0, 0, 0);
    step(16'h945F, 0, 0, 0, 0);
    step(16'h5673, 0, 0, 0, 0);
    step(16'h7A5C, 0, 1, 1, 1);
    step(16'hA3C4, 0, 0, 0, 0);
    step(16'hB6E7, 0, 0, 0, 0);
    step(16'hE090, 0, 0, 0, 0);
    step(16'h0012, 0, 0, 1, 1);
    step(16'h1234, 0, 1, 1, 1);
    // stall during SUB and HLT
    step(16'h2123, 1, 1, 0, 0);
    step(16'hD000, 1, 0, 0, 0);
    step(16'hF000, 1, 0, 0, 0);
    step(16'hF000, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(16'h0123 + 16'(k), 0, 1, 1, 1);
    // reset out of HALT, then JAL
    step(16'hD000, 0, 0, 0, 0, 1'b0);
    step(16'hD000, 0, 0, 0, 0);
    step(16'hD000, 0, 0, 0, 0);
    // randomized traffic, HLT steered away until the tail
    for (int k = 0; k < 120; k++) begin
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF && k < 110) ri[15:12] = 4'hC;
      step(ri, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
